// File: rtl/acc_result_collector_if.sv
// Result-vector bus of the accumulator collector: accumulator beats in,
// indexed result vectors out over a valid/ready handshake.
interface acc_result_collector_if #(
    parameter int dataWidth = 32,
    parameter int pvadd     = 128,
    parameter int idxWidth  = 16
);
    logic                         accValid;
    logic                         accLast;
    logic [dataWidth*pvadd-1:0]   accVector;
    logic                         outValid;
    logic                         outReady;
    logic [dataWidth*pvadd-1:0]   outVector;
    logic [idxWidth-1:0]          outIndex;

    modport master (
        output accValid, accLast, accVector, outReady,
        input  outValid, outVector, outIndex
    );

    modport slave (
        input  accValid, accLast, accVector, outReady,
        output outValid, outVector, outIndex
    );
endinterface

// File: rtl/acc_result_collector.sv
// Captures the final accumulator beat per vertex, applies optional ReLU and
// drains results through a small show-ahead FIFO tagged with a vertex index.
module acc_result_collector #(
    parameter int dataWidth = 32,
    parameter int pvadd     = 128,
    parameter int depth     = 4,
    parameter int idxWidth  = 16,
    parameter int useRelu   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [idxWidth-1:0]         numVertices,
    acc_result_collector_if.slave       bus,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);
    localparam int vecWidth = dataWidth * pvadd;
    localparam int ptrWidth = (depth > 1) ? $clog2(depth) : 1;
    localparam int cntWidth = ptrWidth + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [ptrWidth-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ptrWidth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [cntWidth-1:0]    count_q, count_d;
    logic [idxWidth-1:0]    num_vertices_q, num_vertices_d;
    logic [idxWidth-1:0]    emitted_q, emitted_d;
    logic [idxWidth-1:0]    out_index_q, out_index_d;
    logic                   overflow_q, overflow_d;
    logic [vecWidth-1:0]    fifo_mem_q [depth];

    logic [vecWidth-1:0]    push_data;
    logic                   push_req, push, pop, full, out_valid;

    // ReLU is applied before storage so the output comes straight from the FIFO
    always_comb begin
        push_data = bus.accVector;
        if (useRelu != 0) begin
            for (int l = 0; l < pvadd; l++) begin
                if (bus.accVector[l*dataWidth + dataWidth - 1]) begin
                    push_data[l*dataWidth +: dataWidth] = '0;
                end
            end
        end
    end

    always_comb begin
        full      = (count_q == cntWidth'(depth));
        out_valid = (state_q == RUN) && (count_q != '0);
        pop       = out_valid && bus.outReady;
        push_req  = (state_q == RUN) && bus.accValid && bus.accLast;
        push      = push_req && (!full || pop);

        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        num_vertices_d = num_vertices_q;
        emitted_d      = emitted_q;
        out_index_d    = out_index_q;
        overflow_d     = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            emitted_d   = emitted_q + 1'b1;
            out_index_d = out_index_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_vertices_d = numVertices;
                    emitted_d      = '0;
                    out_index_d    = '0;
                    overflow_d     = 1'b0;
                    state_d        = (numVertices == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop && (emitted_d == num_vertices_q)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            num_vertices_q <= '0;
            emitted_q      <= '0;
            out_index_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            num_vertices_q <= num_vertices_d;
            emitted_q      <= emitted_d;
            out_index_q    <= out_index_d;
            overflow_q     <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.outValid  = out_valid;
    assign bus.outVector = fifo_mem_q[rd_ptr_q];
    assign bus.outIndex  = out_index_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_acc_result_collector.sv
// Randomized scoreboard bench for acc_result_collector: a queue-based model
// predicts every popped vector/index plus busy, done, overflow and outValid.
module tb_acc_result_collector;
    localparam int DW    = 32;
    localparam int PV    = 8;
    localparam int DEPTH = 4;
    localparam int IDXW  = 8;
    localparam int VW    = DW * PV;
    localparam int PV2   = 2;
    localparam int IDXW2 = 4;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        vec_t            vec;
        logic [IDXW-1:0] idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [IDXW-1:0] num_vertices = '0;
    logic            busy, done, overflow;

    logic             start2 = 1'b0;
    logic [IDXW2-1:0] num_vertices2 = '0;
    logic             busy2, done2, overflow2;

    acc_result_collector_if #(.dataWidth(DW), .pvadd(PV), .idxWidth(IDXW)) bus();
    acc_result_collector_if #(.dataWidth(DW), .pvadd(PV2), .idxWidth(IDXW2)) bus2();

    acc_result_collector #(
        .dataWidth(DW), .pvadd(PV), .depth(DEPTH), .idxWidth(IDXW), .useRelu(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .numVertices(num_vertices),
        .bus(bus), .busy(busy), .done(done), .overflow(overflow)
    );

    acc_result_collector #(
        .dataWidth(DW), .pvadd(PV2), .depth(2), .idxWidth(IDXW2), .useRelu(0)
    ) dut_norelu (
        .clk(clk), .rst(rst), .start(start2), .numVertices(num_vertices2),
        .bus(bus2), .busy(busy2), .done(done2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    bit   model_run = 1'b0;
    bit   done_exp = 1'b0;
    bit   model_ovf = 1'b0;
    int   popped = 0;
    int   push_idx = 0;
    int   batch_target = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input vec_t actual, input vec_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t fillLanes(input logic [DW-1:0] v);
        vec_t r;
        for (int l = 0; l < PV; l++) r[l*DW +: DW] = v;
        return r;
    endfunction

    function automatic vec_t randomVec();
        vec_t r;
        for (int l = 0; l < PV; l++) begin
            r[l*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        end
        return r;
    endfunction

    // A lane with its sign set (including -0.0) reads back as +0.0
    function automatic vec_t reluModel(input vec_t v);
        vec_t            r;
        logic [DW-1:0]   lane;
        for (int l = 0; l < PV; l++) begin
            lane = v[l*DW +: DW];
            r[l*DW +: DW] = lane[DW-1] ? '0 : lane;
        end
        return r;
    endfunction

    // Drives one cycle of inputs, then updates the model with what the edge did
    task automatic applyStimulus(input bit do_start, input logic [IDXW-1:0] nv,
                                 input bit beat_valid, input bit beat_last,
                                 input vec_t beat_vec, input bit ready,
                                 input bit do_reset = 1'b0);
        bit   idle, will_pop, want_push, accept;
        exp_t e;
        rst           = do_reset;
        start         = do_start;
        num_vertices  = nv;
        bus.accValid  = beat_valid;
        bus.accLast   = beat_last;
        bus.accVector = beat_vec;
        bus.outReady  = ready;
        idle      = !model_run && !done_exp;
        will_pop  = model_run && (sb.size() > 0) && ready;
        want_push = model_run && beat_valid && beat_last;
        accept    = want_push && ((sb.size() < DEPTH) || will_pop);
        @(posedge clk);
        if (do_reset) begin
            sb.delete();
            model_run = 1'b0;
            model_ovf = 1'b0;
            done_exp  = 1'b0;
        end else begin
            if (accept) begin
                e.vec = reluModel(beat_vec);
                e.idx = IDXW'(push_idx);
                sb.push_back(e);
                push_idx++;
            end else if (want_push) begin
                model_ovf = 1'b1;
            end
            if (do_start && idle) begin
                batch_target = int'(nv);
                popped       = 0;
                push_idx     = 0;
                model_ovf    = 1'b0;
                model_run    = (nv != '0);
                done_exp     = (nv == '0);
            end
        end
        #1;
    endtask

    task automatic runUntilIdle(input int budget, input bit rand_ready);
        int cyc;
        cyc = 0;
        while ((model_run || done_exp) && cyc < budget) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
            cyc++;
        end
        checks++;
        if (model_run || done_exp) begin
            errors++;
            $display("[TB] FAIL drainTimeout: batch still active after %0d cycles, required idle", budget);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    // Monitor: checks status every cycle and pops the scoreboard on each handshake
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("busy", VW'(busy), VW'(model_run));
            checkOutput("done", VW'(done), VW'(done_exp));
            checkOutput("overflow", VW'(overflow), VW'(model_ovf));
            checkOutput("outValid", VW'(bus.outValid), VW'(model_run && (sb.size() > 0)));
            done_exp = 1'b0;
            if (bus.outValid && bus.outReady && !rst && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("outVector", bus.outVector, e.vec);
                checkOutput("outIndex", VW'(bus.outIndex), VW'(e.idx));
                popped++;
                if (popped == batch_target) begin
                    model_run = 1'b0;
                    done_exp  = 1'b1;
                end
            end
        end
    end

    initial begin
        bus.accValid   = 1'b0;
        bus.accLast    = 1'b0;
        bus.accVector  = '0;
        bus.outReady   = 1'b0;
        bus2.accValid  = 1'b0;
        bus2.accLast   = 1'b0;
        bus2.accVector = '0;
        bus2.outReady  = 1'b0;

        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("resetIndex", VW'(bus.outIndex), '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] basic batch with ReLU and an ignored mid-run start");
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, fillLanes(32'h3F80_0000), 1'b1);
        applyStimulus(1'b1, 8'd7, 1'b1, 1'b1, fillLanes(32'hC000_0000), 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, fillLanes(32'h4040_0000), 1'b1);
        runUntilIdle(20, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, randomVec(), 1'b1);

        $display("[TB] non-final beats interleaved");
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, i[0], randomVec(), 1'b1);
        runUntilIdle(20, 1'b0);

        $display("[TB] overflow with consumer stalled");
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, randomVec(), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        runUntilIdle(20, 1'b0);

        $display("[TB] push and pop together while full");
        applyStimulus(1'b1, 8'd6, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, randomVec(), 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, randomVec(), 1'b1);
        runUntilIdle(20, 1'b0);

        $display("[TB] empty batch");
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, '0, 1'b1);
        runUntilIdle(5, 1'b0);

        $display("[TB] reset mid-batch then restart");
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, randomVec(), 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("resetMidIndex", VW'(bus.outIndex), '0);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, randomVec(), 1'b1);
        runUntilIdle(20, 1'b0);

        $display("[TB] randomized batches");
        for (int b = 0; b < 6; b++) begin
            int cyc;
            applyStimulus(1'b1, IDXW'($urandom_range(1, 12)), 1'b0, 1'b0, '0, 1'b0);
            cyc = 0;
            while ((model_run || done_exp) && cyc < 500) begin
                applyStimulus(1'b0, '0, $urandom_range(0, 1) == 1,
                              (push_idx < batch_target) && ($urandom_range(0, 2) != 0),
                              randomVec(), $urandom_range(0, 3) != 0);
                cyc++;
            end
            runUntilIdle(40, 1'b1);
        end

        $display("[TB] pass-through instance without ReLU");
        start2 = 1'b1;
        num_vertices2 = 4'd1;
        @(posedge clk); #1;
        start2 = 1'b0;
        bus2.accValid  = 1'b1;
        bus2.accLast   = 1'b1;
        bus2.accVector = {PV2{32'hBF80_0000}};
        @(posedge clk); #1;
        bus2.accValid = 1'b0;
        checkOutput("noReluValid", VW'(bus2.outValid), VW'(1'b1));
        checkOutput("noReluVector", VW'(bus2.outVector), VW'({PV2{32'hBF80_0000}}));
        checkOutput("noReluIndex", VW'(bus2.outIndex), '0);
        bus2.outReady = 1'b1;
        @(posedge clk); #1;
        bus2.outReady = 1'b0;
        checkOutput("noReluDone", VW'(done2), VW'(1'b1));
        checkOutput("noReluValidAfter", VW'(bus2.outValid), '0);
        @(posedge clk); #1;
        checkOutput("noReluDoneCleared", VW'(done2), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
